idli_sqi_ctrl_m: RTL and testbench

// Producer side of the SQI nibble stream consumed by the execution unit. Drives an

---
 rtl/idli_pkg.sv | 34 +++
 rtl/idli_sqi_ctrl_m.sv | 156 +++++++++++++++
 tb/tb_idli_sqi_ctrl_m.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/idli_pkg.sv
// Shared SQI types, sequencing constants and the address-nibble selector
// used by the SQI fetch controller.
package idli_pkg;

    typedef logic [3:0] sqi_data_t;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CMD   = 3'd1,
        ADDR  = 3'd2,
        DUMMY = 3'd3,
        DATA  = 3'd4
    } sqi_state_t;

    localparam int SQI_ADDR_NIBBLES = 6;
    localparam int SQI_CMD_NIBBLES  = 2;

    // SRAM byte address of a 16b word is {7'b0, word, 1'b0}; nibble 0 is bits [23:20].
    function automatic sqi_data_t sqi_addr_nibble(input logic [15:0] word_addr,
                                                  input logic [2:0]  idx);
        logic [23:0] byte_addr;
        byte_addr = {7'b0000000, word_addr, 1'b0};
        case (idx)
            3'd0:    return byte_addr[23:20];
            3'd1:    return byte_addr[19:16];
            3'd2:    return byte_addr[15:12];
            3'd3:    return byte_addr[11:8];
            3'd4:    return byte_addr[7:4];
            3'd5:    return byte_addr[3:0];
            default: return 4'h0;
        endcase
    endfunction

endpackage

// File: rtl/idli_sqi_ctrl_m.sv
// SQI SRAM read-stream controller: command/address/dummy sequencing and a
// one-nibble output register with valid/accept flow control.
// Optional word-address tracking on o_sqi_pc is enabled by IDLI_SQI_PC_TRACK_EN.
module idli_sqi_ctrl_m
    import idli_pkg::*;
#(
    parameter logic [7:0] CMD_READ     = 8'h03,
    parameter int         DUMMY_CYCLES = 2
) (
    input  logic        i_sqi_gck,
    input  logic        i_sqi_rst_n,
    input  logic        i_sqi_redir,
    input  logic [15:0] i_sqi_redir_addr,
    output sqi_data_t   o_sqi_data,
    output logic        o_sqi_data_vld,
    input  logic        i_sqi_data_acp,
    output logic [15:0] o_sqi_pc,
    output logic        o_sqi_cs_n,
    output logic        o_sqi_sck_en,
    output logic [3:0]  o_sqi_sio,
    output logic        o_sqi_sio_oe,
    input  logic [3:0]  i_sqi_sio
);

    localparam logic [2:0] CMD_LAST   = 3'(SQI_CMD_NIBBLES - 1);
    localparam logic [2:0] ADDR_LAST  = 3'(SQI_ADDR_NIBBLES - 1);
    localparam logic [2:0] DUMMY_LAST = 3'(DUMMY_CYCLES - 1);

    sqi_state_t  state_r;
    logic [2:0]  cnt_r;
    logic [15:0] fetch_addr_r;
    logic        cs_n_r;
    logic        sio_oe_r;
    logic [3:0]  sio_r;
    sqi_data_t   data_r;
    logic        vld_r;
    logic        sck_en_s;

    // SCK must stop in the same cycle a held nibble is refused, otherwise the
    // SRAM would shift out a nibble with nowhere to land.
    assign sck_en_s = (state_r == CMD) || (state_r == ADDR) || (state_r == DUMMY) ||
                      ((state_r == DATA) && (!vld_r || i_sqi_data_acp));

    // Sequencer FSM with registered pad and stream outputs; redirect overrides all states.
    always_ff @(posedge i_sqi_gck or negedge i_sqi_rst_n) begin
        if (!i_sqi_rst_n) begin
            state_r      <= IDLE;
            cnt_r        <= 3'd0;
            fetch_addr_r <= 16'h0000;
            cs_n_r       <= 1'b1;
            sio_oe_r     <= 1'b0;
            sio_r        <= 4'h0;
            data_r       <= 4'h0;
            vld_r        <= 1'b0;
        end else if (i_sqi_redir) begin
            state_r      <= IDLE;
            cnt_r        <= 3'd0;
            fetch_addr_r <= i_sqi_redir_addr;
            cs_n_r       <= 1'b1;
            sio_oe_r     <= 1'b0;
            sio_r        <= 4'h0;
            vld_r        <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    state_r  <= CMD;
                    cnt_r    <= 3'd0;
                    cs_n_r   <= 1'b0;
                    sio_oe_r <= 1'b1;
                    sio_r    <= CMD_READ[7:4];
                end
                CMD: begin
                    if (cnt_r == CMD_LAST) begin
                        state_r <= ADDR;
                        cnt_r   <= 3'd0;
                        sio_r   <= sqi_addr_nibble(fetch_addr_r, 3'd0);
                    end else begin
                        cnt_r <= cnt_r + 3'd1;
                        sio_r <= CMD_READ[3:0];
                    end
                end
                ADDR: begin
                    if (cnt_r == ADDR_LAST) begin
                        state_r  <= DUMMY;
                        cnt_r    <= 3'd0;
                        sio_oe_r <= 1'b0;
                        sio_r    <= 4'h0;
                    end else begin
                        cnt_r <= cnt_r + 3'd1;
                        sio_r <= sqi_addr_nibble(fetch_addr_r, cnt_r + 3'd1);
                    end
                end
                DUMMY: begin
                    if (cnt_r == DUMMY_LAST) begin
                        state_r <= DATA;
                        cnt_r   <= 3'd0;
                    end else begin
                        cnt_r <= cnt_r + 3'd1;
                    end
                end
                DATA: begin
                    // Every clocked SCK period in DATA delivers exactly one nibble.
                    if (sck_en_s) begin
                        data_r <= i_sqi_sio;
                        vld_r  <= 1'b1;
                    end else begin
                        vld_r  <= vld_r;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    cnt_r   <= 3'd0;
                    cs_n_r  <= 1'b1;
                end
            endcase
        end
    end

`ifdef IDLI_SQI_PC_TRACK_EN
    logic [15:0] pc_r;
    logic [1:0]  sub_r;

    // Word counter: advances after the fourth accepted nibble of each word.
    always_ff @(posedge i_sqi_gck or negedge i_sqi_rst_n) begin
        if (!i_sqi_rst_n) begin
            pc_r  <= 16'h0000;
            sub_r <= 2'd0;
        end else if (i_sqi_redir) begin
            pc_r  <= i_sqi_redir_addr;
            sub_r <= 2'd0;
        end else if (vld_r && i_sqi_data_acp) begin
            sub_r <= sub_r + 2'd1;
            if (sub_r == 2'd3) begin
                pc_r <= pc_r + 16'd1;
            end else begin
                pc_r <= pc_r;
            end
        end else begin
            pc_r  <= pc_r;
            sub_r <= sub_r;
        end
    end

    assign o_sqi_pc = pc_r;
`else
    assign o_sqi_pc = 16'h0000;
`endif

    assign o_sqi_data     = data_r;
    assign o_sqi_data_vld = vld_r;
    assign o_sqi_cs_n     = cs_n_r;
    assign o_sqi_sck_en   = sck_en_s;
    assign o_sqi_sio      = sio_r;
    assign o_sqi_sio_oe   = sio_oe_r;

endmodule

// File: tb/tb_idli_sqi_ctrl_m.sv
// Bench for idli_sqi_ctrl_m: behavioural SQI SRAM, reset-start vector table,
// directed corner sequences and a randomized run against a stream model.
module tb_idli_sqi_ctrl_m;
    import idli_pkg::*;

    localparam int D = 2;

    logic        gck = 1'b0;
    logic        rst_n = 1'b0;
    logic        redir = 1'b0;
    logic [15:0] redir_addr = 16'h0000;
    logic        acp = 1'b0;
    sqi_data_t   data;
    logic        vld;
    logic [15:0] pc;
    logic        cs_n;
    logic        sck_en;
    logic [3:0]  sio;
    logic        sio_oe;
    logic [3:0]  sio_in;

    int passed = 0;
    int total  = 0;

    int          phase = 0;
    logic [31:0] sh = 32'h0;

    idli_sqi_ctrl_m dut (
        .i_sqi_gck        (gck),
        .i_sqi_rst_n      (rst_n),
        .i_sqi_redir      (redir),
        .i_sqi_redir_addr (redir_addr),
        .o_sqi_data       (data),
        .o_sqi_data_vld   (vld),
        .i_sqi_data_acp   (acp),
        .o_sqi_pc         (pc),
        .o_sqi_cs_n       (cs_n),
        .o_sqi_sck_en     (sck_en),
        .o_sqi_sio        (sio),
        .o_sqi_sio_oe     (sio_oe),
        .i_sqi_sio        (sio_in)
    );

    always #5 gck = ~gck;

    // Memory contents as a function of nibble index (2^18 nibbles = 2^17 bytes).
    function automatic logic [3:0] mem_nib(input int n);
        int m;
        m = n & 32'h3FFFF;
        return 4'(((m & 15) + 1) ^ ((m >> 4) & 15) ^ ((m >> 8) & 15));
    endfunction

    function automatic logic [3:0] sram_drive(input int ph, input logic [31:0] s);
        if (ph >= 8 + D) return mem_nib(int'(s[16:0]) * 2 + ph - 8 - D);
        else return 4'h0;
    endfunction

    assign sio_in = sram_drive(phase, sh);

    // SRAM: counts SCK periods while selected; 8 command/address periods, then dummy, then data.
    always @(posedge gck) begin
        if (cs_n) begin
            phase <= 0;
        end else if (sck_en) begin
            if (phase < 8) sh <= {sh[27:0], sio};
            phase <= phase + 1;
        end
    end

    function automatic logic [3:0] exp_nib(input logic [15:0] w, input int k);
        return mem_nib(int'(w) * 4 + k);
    endfunction

    function automatic logic [15:0] exp_pc(input logic [15:0] w, input int k);
`ifdef IDLI_SQI_PC_TRACK_EN
        return 16'(int'(w) + k / 4);
`else
        return 16'(int'(w) * 0 + k * 0);
`endif
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        else passed++;
    endtask

    task automatic cyc(input logic a, input logic r, input logic [15:0] ad);
        acp = a;
        redir = r;
        redir_addr = ad;
        @(negedge gck);
    endtask

    task automatic wait_vld(input int max, output int n);
        n = 0;
        while (vld !== 1'b1 && n < max) begin
            cyc(1'b1, 1'b0, 16'h0000);
            n++;
        end
        chk("vld_timeout", 32'(vld), 32'd1);
    endtask

    task automatic accept_chk(input string nm, input logic [15:0] w, inout int k);
        chk({nm, "_data"}, 32'(data), 32'(exp_nib(w, k)));
        chk({nm, "_pc"}, 32'(pc), 32'(exp_pc(w, k)));
        cyc(1'b1, 1'b0, 16'h0000);
        k++;
    endtask

    typedef struct {
        logic [3:0] sio;
        logic       oe;
        logic       cs_n;
        logic       sck;
        logic       vld;
        logic [3:0] data;
    } vec_t;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t       vt[15];
        logic [3:0] addr_nib[8];
        int         n;
        int         k;
        int         base;
        int         since;
        bit         seen;
        bit         pend_stall;
        bit         pend_redir;
        logic [3:0] stall_data;
        logic       a;
        logic       r;
        logic [15:0] ad;

        // Reset-start vectors: index t is sampled after the t-th clock edge past reset release.
        for (int t = 0; t < 15; t++) vt[t] = '{4'h0, 1'b1, 1'b0, 1'b1, 1'b0, 4'h0};
        vt[1].sio = 4'h3;
        for (int t = 8; t < 15; t++) vt[t].oe = 1'b0;
        for (int t = 11; t < 15; t++) begin
            vt[t].vld  = 1'b1;
            vt[t].data = 4'(t - 10);
        end
        addr_nib[0] = 4'h0; addr_nib[1] = 4'h3; addr_nib[2] = 4'h0; addr_nib[3] = 4'h0;
        addr_nib[4] = 4'h0; addr_nib[5] = 4'h2; addr_nib[6] = 4'h4; addr_nib[7] = 4'h6;

        rst_n = 1'b0;
        @(negedge gck);
        chk("rst_cs_n", 32'(cs_n), 32'd1);
        chk("rst_sck_en", 32'(sck_en), 32'd0);
        chk("rst_sio_oe", 32'(sio_oe), 32'd0);
        chk("rst_sio", 32'(sio), 32'd0);
        chk("rst_vld", 32'(vld), 32'd0);
        chk("rst_data", 32'(data), 32'd0);
        chk("rst_pc", 32'(pc), 32'd0);
        rst_n = 1'b1;
        acp = 1'b1;
        for (int t = 0; t < 15; t++) begin
            @(negedge gck);
            chk($sformatf("start%0d_sio", t), 32'(sio), 32'(vt[t].sio));
            chk($sformatf("start%0d_oe", t), 32'(sio_oe), 32'(vt[t].oe));
            chk($sformatf("start%0d_cs_n", t), 32'(cs_n), 32'(vt[t].cs_n));
            chk($sformatf("start%0d_sck", t), 32'(sck_en), 32'(vt[t].sck));
            chk($sformatf("start%0d_vld", t), 32'(vld), 32'(vt[t].vld));
            chk($sformatf("start%0d_data", t), 32'(data), 32'(vt[t].data));
            chk($sformatf("start%0d_pc", t), 32'(pc), 32'd0);
        end

        // Redirect while streaming: one CS-high cycle, then command and address nibbles.
        cyc(1'b0, 1'b1, 16'h0123);
        chk("redir_cs_n", 32'(cs_n), 32'd1);
        chk("redir_vld", 32'(vld), 32'd0);
        chk("redir_sck", 32'(sck_en), 32'd0);
        for (int i = 0; i < 8; i++) begin
            cyc(1'b1, 1'b0, 16'h0000);
            chk($sformatf("redir_nib%0d", i), 32'(sio), 32'(addr_nib[i]));
            chk($sformatf("redir_oe%0d", i), 32'(sio_oe), 32'd1);
            chk($sformatf("redir_cs%0d", i), 32'(cs_n), 32'd0);
        end
        wait_vld(20, n);
        chk("redir_latency", 32'(n), 32'd4);
        chk("sram_cmd", 32'(sh[31:24]), 32'h03);
        chk("sram_addr", 32'(sh[23:0]), 32'h000246);
        k = 0;
        accept_chk("r0123", 16'h0123, k);
        accept_chk("r0123", 16'h0123, k);

        // Five-cycle stall mid-word.
        for (int j = 0; j < 5; j++) begin
            acp = 1'b0;
            redir = 1'b0;
            #1;
            chk("stall_sck", 32'(sck_en), 32'd0);
            @(negedge gck);
            chk("stall_vld", 32'(vld), 32'd1);
            chk("stall_data", 32'(data), 32'(exp_nib(16'h0123, k)));
        end
        for (int j = 0; j < 6; j++) accept_chk("resume", 16'h0123, k);

        // Redirect coincident with an accept: that nibble is dropped.
        cyc(1'b1, 1'b1, 16'hBEEF);
        chk("drop_vld", 32'(vld), 32'd0);
        chk("drop_pc", 32'(pc), 32'(exp_pc(16'hBEEF, 0)));
        wait_vld(30, n);
        chk("drop_latency", 32'(n), 32'd12);
        k = 0;
        accept_chk("beef", 16'hBEEF, k);

        // Second redirect while in the idle cycle re-latches the address.
        cyc(1'b0, 1'b1, 16'h1111);
        cyc(1'b1, 1'b1, 16'h2222);
        chk("idle_redir_cs_n", 32'(cs_n), 32'd1);
        wait_vld(30, n);
        chk("idle_redir_latency", 32'(n), 32'd12);
        k = 0;
        accept_chk("r2222", 16'h2222, k);

        // Word-address wrap.
        cyc(1'b0, 1'b1, 16'hFFFF);
        wait_vld(30, n);
        k = 0;
        for (int j = 0; j < 8; j++) accept_chk("wrap", 16'hFFFF, k);

        // Asynchronous reset in the middle of the address phase.
        cyc(1'b0, 1'b1, 16'h5555);
        for (int j = 0; j < 3; j++) cyc(1'b1, 1'b0, 16'h0000);
        chk("pre_rst_oe", 32'(sio_oe), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_cs_n", 32'(cs_n), 32'd1);
        chk("arst_oe", 32'(sio_oe), 32'd0);
        chk("arst_vld", 32'(vld), 32'd0);
        chk("arst_sck", 32'(sck_en), 32'd0);
        chk("arst_sio", 32'(sio), 32'd0);
        @(negedge gck);
        rst_n = 1'b1;
        wait_vld(30, n);
        chk("arst_latency", 32'(n), 32'd12);
        k = 0;
        accept_chk("refetch", 16'h0000, k);

        // Randomized stream against the model.
        base = 0; k = 0; since = 0; seen = 1'b1; pend_stall = 1'b0; pend_redir = 1'b0;
        stall_data = 4'h0;
        for (int i = 0; i < 3000; i++) begin
            if (pend_redir) begin
                chk("rnd_redir_vld", 32'(vld), 32'd0);
                chk("rnd_redir_cs_n", 32'(cs_n), 32'd1);
            end
            if (pend_stall) begin
                chk("rnd_stall_vld", 32'(vld), 32'd1);
                chk("rnd_stall_data", 32'(data), 32'(stall_data));
            end
            if (vld && !seen) begin
                chk("rnd_latency", 32'(since), 32'd13);
                seen = 1'b1;
            end
            a  = ($urandom % 10) < 7;
            r  = (i == 0) || (($urandom % 60) == 0);
            ad = (($urandom % 4) == 0) ? 16'(16'hFFF0 + ($urandom % 16)) : 16'($urandom);
            pend_stall = vld && !a && !r;
            stall_data = data;
            if (vld && a && !r) begin
                chk("rnd_data", 32'(data), 32'(exp_nib(16'(base), k)));
                chk("rnd_pc", 32'(pc), 32'(exp_pc(16'(base), k)));
                k++;
            end
            pend_redir = r;
            acp = a;
            redir = r;
            redir_addr = ad;
            #1;
            if (vld) chk("rnd_sck", 32'(sck_en), 32'(a));
            if (r) begin
                base = int'(ad);
                k = 0;
                since = 0;
                seen = 1'b0;
            end
            @(negedge gck);
            since++;
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
